// File: rtl/slt_multicycle.sv
// Multi-cycle comparator: signed/unsigned less-than and equality, evaluated K bits per cycle,
// LSB chunk first, with valid/ready handshakes on both sides.
module slt_multicycle #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out,
  output logic         busy
);

  localparam int NC = N / K;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [N-1:0]   a_r, b_r;
  logic [1:0]     mode_r;
  logic [IW-1:0]  idx;
  logic           carry, eq_acc;
  logic [K-1:0]   a_c, b_c;
  logic [K:0]     sum;
  logic           accept, step, last, ack, res;

  assign a_c = a_r[idx*K +: K];
  assign b_c = b_r[idx*K +: K];
  // a - b as a + ~b + 1, one chunk at a time; carry holds the running borrow-complement
  assign sum = {1'b0, a_c} + {1'b0, ~b_c} + (K+1)'(carry);

  always_comb begin
    unique case (mode_r)
      2'b00:   res = sum[K-1] ^ ((a_r[N-1] ^ sum[K-1]) & (a_r[N-1] ^ b_r[N-1]));
      2'b01:   res = ~sum[K];
      2'b10:   res = eq_acc & (a_c == b_c);
      default: res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    ack     = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (idx == LAST) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: if (out_ready) begin
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      mode_r    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      eq_acc    <= 1'b0;
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else begin
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        mode_r <= mode;
        idx    <= '0;
        carry  <= 1'b1;
        eq_acc <= 1'b1;
      end
      if (step) begin
        carry  <= sum[K];
        eq_acc <= eq_acc & (a_c == b_c);
        // index parks at 0 after the last chunk so the part-select never leaves the operand
        idx    <= last ? '0 : idx + 1'b1;
      end
      if (last) begin
        out_valid <= 1'b1;
        out       <= res;
      end
      if (ack) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slt_multicycle.sv
// Bench for slt_multicycle: directed vector table and corner sequences on N=32/K=8,
// then a cycle-accurate model sweep over N=32/K=8 and N=K=8 instances.
module tb_slt_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv  [2];
  logic        ir  [2];
  logic        ovl [2];
  logic        ordy[2];
  logic        outs[2];
  logic        bs  [2];
  logic [1:0]  md  [2];
  logic [31:0] a0, b0;
  logic [7:0]  a1, b1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  slt_multicycle #(.N(32), .K(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0),
    .mode(md[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .out(outs[0]), .busy(bs[0])
  );

  slt_multicycle #(.N(8), .K(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1),
    .mode(md[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .out(outs[1]), .busy(bs[1])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic        exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference: left-justify the n-bit operands so 32-bit compares keep their order.
  function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] m, input int n);
    logic [31:0] sa, sb;
    sa = a << (32 - n);
    sb = b << (32 - n);
    case (m)
      2'b00:   return $signed(sa) < $signed(sb);
      2'b01:   return sa < sb;
      2'b10:   return sa == sb;
      default: return 1'b0;
    endcase
  endfunction

  // Called at the negedge following the acceptance edge of dut32.
  task automatic finish_op(input string nm, input logic exp);
    int lat = 0;
    while (!ovl[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 4);
    chk({nm, " out"}, outs[0], exp);
    chk({nm, " busy in DONE"}, bs[0], 1'b1);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk({nm, " in_ready after ack"}, ir[0], 1'b1);
    chk({nm, " out_valid after ack"}, ovl[0], 1'b0);
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic exp);
    @(negedge clk);
    chk({nm, " in_ready idle"}, ir[0], 1'b1);
    a0 = a; b0 = b; md[0] = m; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    a0 = ~a; b0 = a;
    finish_op(nm, exp);
  endtask

  task automatic sweep(input int inst, input int nops, input int n);
    int st = 0, cnt = 0, done = 0, cyc = 0;
    logic [31:0] ca = '0, cb = '0, ra, rb;
    logic [1:0]  cm = '0, rm;
    logic        mo = 1'b0, mov = 1'b0, riv, ror;
    string nm;
    nm = (inst == 0) ? "sweep32" : "sweep8";
    while (done < nops) begin
      @(negedge clk);
      if (cyc > 60000) begin
        chk({nm, " cycle budget"}, done, nops);
        break;
      end
      chk({nm, " out_valid"}, ovl[inst], mov);
      chk({nm, " in_ready"}, ir[inst], st == 0);
      chk({nm, " busy"}, bs[inst], st != 0);
      if (mov) chk({nm, " out"}, outs[inst], mo);
      ra  = $urandom;
      rb  = ($urandom_range(3) == 0) ? ra : $urandom;
      rm  = 2'($urandom_range(3));
      riv = ($urandom_range(3) != 0);
      ror = ($urandom_range(3) != 0);
      iv[inst] = riv; ordy[inst] = ror; md[inst] = rm;
      if (inst == 0) begin a0 = ra; b0 = rb; end
      else begin a1 = ra[7:0]; b1 = rb[7:0]; end
      @(posedge clk);
      cyc++;
      case (st)
        0: if (riv) begin
          ca = ra; cb = rb; cm = rm; cnt = 0; st = 1;
        end
        1: begin
          cnt++;
          if (cnt == n / 8) begin
            st = 2; mov = 1'b1; mo = ref_cmp(ca, cb, cm, n);
          end
        end
        default: if (ror) begin
          st = 0; mov = 1'b0; done++;
        end
      endcase
    end
    iv[inst] = 1'b0;
    ordy[inst] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b1};
    vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 2'b01, 1'b0};
    vt[2]  = '{32'h7FFFFFFF, 32'h80000000, 2'b00, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h80000000, 2'b01, 1'b1};
    vt[4]  = '{32'h12345678, 32'h12345678, 2'b10, 1'b1};
    vt[5]  = '{32'h12345679, 32'h12345678, 2'b10, 1'b0};
    vt[6]  = '{32'h80000000, 32'h00000000, 2'b00, 1'b1};
    vt[7]  = '{32'h00000001, 32'hFFFFFFFF, 2'b00, 1'b0};
    vt[8]  = '{32'h00000000, 32'h00000000, 2'b01, 1'b0};
    vt[9]  = '{32'h00000005, 32'h00000005, 2'b00, 1'b0};
    vt[10] = '{32'h00000003, 32'h00000005, 2'b11, 1'b0};
    vt[11] = '{32'h000000FF, 32'h00000100, 2'b01, 1'b1};
    vt[12] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 2'b10, 1'b0};

    for (int unsigned i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; md[i] = '0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset in_ready", ir[0], 1'b1);
    chk("reset out_valid", ovl[0], 1'b0);
    chk("reset busy", bs[0], 1'b0);
    chk("reset out", outs[0], 1'b0);
    chk("reset in_ready n8", ir[1], 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].mode, vt[i].exp);

    // Backpressure: hold DONE for 5 cycles while new requests are offered and ignored.
    @(negedge clk);
    a0 = 32'hFFFFFFFF; b0 = 32'h00000001; md[0] = 2'b00; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a0 = 32'h00000001; b0 = 32'hFFFFFFFF;
    for (int unsigned c = 0; c < 3; c++) @(negedge clk);
    chk("bp pre-done out_valid", ovl[0], 1'b0);
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp out_valid", ovl[0], 1'b1);
      chk("bp out", outs[0], 1'b1);
      chk("bp in_ready", ir[0], 1'b0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp release in_ready", ir[0], 1'b1);
    chk("bp release out_valid", ovl[0], 1'b0);

    // Asynchronous reset after chunk 1, then an operation accepted on the first edge.
    @(negedge clk);
    a0 = 32'h00000001; b0 = 32'h00000002; md[0] = 2'b01; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst out_valid", ovl[0], 1'b0);
    chk("midrun rst in_ready", ir[0], 1'b1);
    chk("midrun rst busy", bs[0], 1'b0);
    #1 rst = 1'b0;
    a0 = 32'h80000000; b0 = 32'h00000000; md[0] = 2'b00; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("post-rst accepted", bs[0], 1'b1);
    finish_op("post-rst op", 1'b1);

    fork
      sweep(0, 7000, 32);
      sweep(1, 3000, 8);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/slt_multicycle.md
SLT_MULTICYCLE -- requirements
Module: slt_multicycle

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter K, default 8, meaning bits processed per RUN cycle; N SHALL be an integer multiple of K, with N/K >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operands and mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have ports a and b, input, N bits each: the operands.
REQ-008 SHALL have port mode, input, 2 bits: 00 = signed less-than, 01 = unsigned less-than, 10 = equal, 11 = reserved.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out, output, 1 bit: comparison result.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, decoded combinationally from state.
REQ-015 SHALL accept an operation on an edge where in_valid & in_ready: capture a, b and mode; set chunk index to 0, carry to 1 and eq_acc to 1; go to RUN.
REQ-016 In RUN, each edge SHALL process chunk i (bits i*K+K-1 down to i*K), LSB chunk first:
- {carry, sum_chunk} = a_chunk + ~b_chunk + carry;
- eq_acc &= (a_chunk == b_chunk);
- increment i.
REQ-017 On the edge processing the last chunk (i = N/K-1), SHALL register the result and go to DONE:
- 00: sum[N-1] ^ ((a[N-1] ^ sum[N-1]) & (a[N-1] ^ b[N-1]));
- 01: ~carry_out;
- 10: eq_acc including the final chunk;
- 11: 0.
REQ-018 SHALL assert out_valid exactly N/K cycles after the acceptance edge; latency is 4 for the default parameters.
REQ-019 In DONE, SHALL hold out_valid = 1 and hold out stable until out_ready = 1; on that edge SHALL go to IDLE and clear out_valid.
REQ-020 SHALL ignore in_valid while not in IDLE; captured operands SHALL NOT change during RUN or DONE.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL use internal arithmetic no wider than K+1 bits per cycle; a single N-bit adder SHALL NOT be used.
REQ-023 When N = K, SHALL complete in one RUN cycle and go straight to DONE.
REQ-024 The minimum issue interval SHALL be N/K + 2 cycles when out_ready is held at 1.

Reset
REQ-025 On rst high, SHALL immediately, with no clock required, force state IDLE, out_valid = 0, out = 0, chunk index 0, carry 0 and eq_acc 0; in_ready follows as 1 and busy as 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no result produced; the first edge after rst falls SHALL be able to accept a new operation.

Verification
REQ-027 With N=32, K=8 and mode=00, the bench SHALL apply a=0xFFFFFFFF (-1), b=0x00000001 -> out_valid 4 cycles after acceptance, out=1.
REQ-028 With mode=01 and the same operands, the bench SHALL check out=0; with a=0x7FFFFFFF, b=0x80000000 it SHALL check mode 00 gives out=0 and mode 01 gives out=1 (overflow case).
REQ-029 With mode=10, the bench SHALL apply a=b=0x12345678 -> out=1, then a=0x12345679, b=0x12345678 -> out=0, where only chunk 0 differs.
REQ-030 For backpressure, the bench SHALL hold out_ready=0 for 5 cycles in DONE -> out_valid and out stable and in_ready=0 throughout; then raise out_ready -> IDLE next edge.
REQ-031 The bench SHALL assert rst asynchronously mid-RUN (after chunk 1) -> out_valid=0 and in_ready=1 immediately; a subsequent a=0x80000000, b=0x00000000, mode=00 operation gives out=1.
REQ-032 The bench SHALL run a randomised sweep of 10,000 operations over all modes with random in_valid and out_ready, checking against a reference model, including N=K=8.
